pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipeline. It drives write enables, bubble and flush for the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It generates operand forwarding selects for the ID stage and sequences the multi-cycle divider (HI/LO), stalling ID while a result is pending. It also counts stall cycles for performance monitoring.

Parameters:
DIV_LAT, 32, divider latency in cycles from launch to HI/LO valid (range 2..63)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  rising-edge clock
clrn  in  1  asynchronous reset, active-high (clrn=1 clears all state)
id_rs  in  5  ID-stage source register rs
id_rt  in  5  ID-stage source register rt
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_is_div  in  1  ID instruction is DIV/DIVU
id_use_hilo  in  1  ID instruction reads HI/LO (MFHI/MFLO)
id_branch_taken  in  1  ID branch/jump resolved taken
exe_rn  in  5  EXE destination register
exe_wreg  in  1  EXE writes register file
exe_m2reg  in  1  EXE instruction is a load
mem_rn  in  5  MEM destination register
mem_wreg  in  1  MEM writes register file
mem_m2reg  in  1  MEM instruction is a load
fwda  out  2  rs operand select: 00 regfile, 01 exe_alu, 10 mem_alu, 11 mem_mo
fwdb  out  2  rt operand select, same encoding
wpcir  out  1  PC and IF/ID write enable (0 = hold)
id_bubble  out  1  load NOP into ID/EXE instead of decoded controls
ifid_flush  out  1  clear IF/ID on next edge
div_start  out  1  one-cycle launch pulse to divider
div_busy  out  1  divider running
div_done  out  1  one-cycle pulse, HI/LO valid
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Forwarding (combinational): a source is eligible only if its use flag = 1 and its register != 0. Check EXE first: exe_wreg & exe_rn==src & !exe_m2reg -> 01. Otherwise check MEM: mem_wreg & mem_rn==src -> 10 if !mem_m2reg, else 11. Otherwise 00. EXE wins over MEM for the same register.
- Load-use stall lu = exe_wreg & exe_m2reg & exe_rn!=0 & (use_rs & rs==exe_rn | use_rt & rt==exe_rn).
- Divider stall ds = div_busy & (id_is_div | id_use_hilo).
- stall = lu | ds. When stall=1: wpcir=0, id_bubble=1, ifid_flush=0, div_start=0.
- Flush: ifid_flush = id_branch_taken & !stall. A stalled branch is re-evaluated the following cycle.
- Divider FSM states:
  - IDLE: div_busy=0.
  - RUN: div_busy=1; cnt loaded with DIV_LAT-1 on entry, decrements each cycle; at cnt==0 go to DONE.
  - DONE: lasts one cycle; div_done=1, div_busy=0, then returns to IDLE.
- div_start = id_is_div & !stall, combinational. It is legal in IDLE and in DONE (back-to-back divides); the FSM enters RUN on that edge.
- From launch, div_done asserts exactly DIV_LAT cycles after the div_start cycle.
- stall_cnt increments on each edge where stall=1 and saturates at all-ones.
- Reset (clrn=1, any time, including mid-divide):
  - FSM to IDLE, cnt=0, stall_cnt=0.
  - div_busy=0, div_done=0.
  - Combinational outputs follow their inputs. With FSM IDLE, wpcir=1 and id_bubble=0 unless a load-use condition is present.
- Simultaneous events: a load-use stall during RUN does not pause the divider count. div_done and a new id_use_hilo in the same cycle proceed with no stall, since div_busy=0 in DONE.

Test Plan:
- Forwarding: exe_rn=5, exe_wreg=1, exe_m2reg=0, mem_rn=5, mem_wreg=1, id_rs=5, use_rs=1 -> fwda=01. Drop exe_wreg -> fwda=10. Set mem_m2reg=1 -> fwda=11. id_rs=0 -> fwda=00.
- Load-use: exe_m2reg=1, exe_wreg=1, exe_rn=8, id_rt=8, use_rt=1 -> wpcir=0, id_bubble=1 for one cycle. Next cycle (load in MEM) -> fwdb=11, wpcir=1.
- Divide with DIV_LAT=4: id_is_div=1 at cycle 0 -> div_start=1 at 0, div_busy=1 cycles 1-4?? no: div_busy=1 cycles 1-3, div_done=1 at cycle 4. MFHI held in ID from cycle 1 -> wpcir=0 cycles 1-3, released at cycle 4. stall_cnt=3.
- Branch: id_branch_taken=1 with no hazard -> ifid_flush=1. id_branch_taken=1 with load-use -> ifid_flush=0 that cycle, =1 the next cycle.
- Reset mid-divide: assert clrn at cycle 2 of RUN -> div_busy=0, stall_cnt=0 immediately. After release, id_use_hilo=1 -> no stall and no div_done pulse.
- Saturation with CNT_W=4: hold lu for 20 cycles -> stall_cnt stays at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central hazard controller for the 5-stage pipeline.
//   - Operand forwarding selects for the ID stage (fwda / fwdb).
//   - Load-use and divider stalls (wpcir, id_bubble), IF/ID flush on taken
//     branches that are not stalled.
//   - Multi-cycle divider sequencer (div_start / div_busy / div_done).
//   - Saturating stall-cycle counter for performance monitoring.
//
// Ports:
//   clk, clrn                 clock, asynchronous active-high reset
//   id_rs, id_rt              ID-stage source registers
//   id_use_rs, id_use_rt      ID instruction reads rs / rt
//   id_is_div, id_use_hilo    ID instruction is DIV/DIVU, reads HI/LO
//   id_branch_taken           ID branch/jump resolved taken
//   exe_rn/wreg/m2reg         EXE destination, write enable, load flag
//   mem_rn/wreg/m2reg         MEM destination, write enable, load flag
//   fwda, fwdb                00 regfile, 01 exe_alu, 10 mem_alu, 11 mem_mo
//   wpcir                     PC and IF/ID write enable (0 = hold)
//   id_bubble                 load NOP into ID/EXE
//   ifid_flush                clear IF/ID on next edge
//   div_start                 one-cycle divider launch pulse
//   div_busy, div_done        divider running / HI-LO valid pulse
//   stall_cnt                 saturating count of stall cycles
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_div,
    input  logic             id_use_hilo,
    input  logic             id_branch_taken,
    input  logic [4:0]       exe_rn,
    input  logic             exe_wreg,
    input  logic             exe_m2reg,
    input  logic [4:0]       mem_rn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             id_bubble,
    output logic             ifid_flush,
    output logic             div_start,
    output logic             div_busy,
    output logic             div_done,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam logic [5:0] CNT_LOAD = 6'(DIV_LAT - 1);

    div_state_t state, state_next;
    logic [5:0] cnt, cnt_next;
    logic       lu, ds, stall;

    // EXE has priority; a load in EXE cannot forward and falls through to MEM.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       use_src,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (src != 5'd0)) begin
            if (e_wreg && (e_rn == src) && !e_m2reg)
                sel = 2'b01;
            else if (m_wreg && (m_rn == src))
                sel = m_m2reg ? 2'b11 : 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        fwda = fwd_sel(id_rs, id_use_rs, exe_rn, exe_wreg, exe_m2reg,
                       mem_rn, mem_wreg, mem_m2reg);
        fwdb = fwd_sel(id_rt, id_use_rt, exe_rn, exe_wreg, exe_m2reg,
                       mem_rn, mem_wreg, mem_m2reg);
    end

    always_comb begin
        lu = exe_wreg && exe_m2reg && (exe_rn != 5'd0) &&
             ((id_use_rs && (id_rs == exe_rn)) ||
              (id_use_rt && (id_rt == exe_rn)));
        ds = div_busy && (id_is_div || id_use_hilo);
        stall      = lu || ds;
        wpcir      = !stall;
        id_bubble  = stall;
        ifid_flush = id_branch_taken && !stall;
        div_start  = id_is_div && !stall;
    end

    // State register, countdown and stall counter.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // cnt holds DIV_LAT-1 on the first RUN cycle and reaches 0 on the edge
    // into DONE, so RUN lasts DIV_LAT-1 cycles and div_done lands exactly
    // DIV_LAT cycles after the div_start cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (div_start) begin
                    state_next = RUN;
                    cnt_next   = CNT_LOAD;
                end
            end
            RUN: begin
                cnt_next = cnt - 6'd1;
                if (cnt <= 6'd1)
                    state_next = DONE;
            end
            DONE: begin
                if (div_start) begin
                    state_next = RUN;
                    cnt_next   = CNT_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        div_busy = (state == RUN);
        div_done = (state == DONE);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (DIV_LAT=4, CNT_W=4).
//   Directed scenarios plus a randomized run against a cycle-level model in
//   which the divider is tracked as "cycles left until HI/LO valid".
module tb_pipe_hazard_ctrl;

    localparam int DIV_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int SC_MAX  = 15;

    logic             clk;
    logic             clrn;
    logic [4:0]       id_rs, id_rt, exe_rn, mem_rn;
    logic             id_use_rs, id_use_rt, id_is_div, id_use_hilo, id_branch_taken;
    logic             exe_wreg, exe_m2reg, mem_wreg, mem_m2reg;
    logic [1:0]       fwda, fwdb;
    logic             wpcir, id_bubble, ifid_flush, div_start, div_busy, div_done;
    logic [CNT_W-1:0] stall_cnt;

    int checks;
    int failures;

    // Model state: m_left = -1 idle, >0 busy, 0 = HI/LO valid this cycle.
    int m_left;
    int m_sc;

    logic [1:0]       e_fwda, e_fwdb;
    logic             e_wpcir, e_bub, e_flush, e_start, e_busy, e_done, e_stall;
    logic [CNT_W-1:0] e_sc;

    pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_div(id_is_div), .id_use_hilo(id_use_hilo),
        .id_branch_taken(id_branch_taken),
        .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
        .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .id_bubble(id_bubble),
        .ifid_flush(ifid_flush), .div_start(div_start),
        .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic use_src);
        if (!use_src || src == 5'd0) return 2'b00;
        if (exe_wreg && exe_rn == src && !exe_m2reg) return 2'b01;
        if (mem_wreg && mem_rn == src) return mem_m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic model_eval();
        logic lu_m;
        lu_m = exe_wreg && exe_m2reg && exe_rn != 5'd0 &&
               ((id_use_rs && id_rs == exe_rn) || (id_use_rt && id_rt == exe_rn));
        e_fwda  = ref_fwd(id_rs, id_use_rs);
        e_fwdb  = ref_fwd(id_rt, id_use_rt);
        e_busy  = (m_left > 0);
        e_done  = (m_left == 0);
        e_stall = lu_m || (e_busy && (id_is_div || id_use_hilo));
        e_wpcir = !e_stall;
        e_bub   = e_stall;
        e_flush = id_branch_taken && !e_stall;
        e_start = id_is_div && !e_stall;
        e_sc    = CNT_W'(m_sc);
    endtask

    // Advance one clock; model follows the inputs present before the edge.
    task automatic step();
        model_eval();
        @(posedge clk);
        if (clrn) begin
            m_left = -1;
            m_sc   = 0;
        end else begin
            if (e_start) m_left = DIV_LAT - 1;
            else if (m_left > 0) m_left = m_left - 1;
            else m_left = -1;
            if (e_stall && m_sc < SC_MAX) m_sc = m_sc + 1;
        end
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_is_div = 0; id_use_hilo = 0; id_branch_taken = 0;
        exe_rn = '0; exe_wreg = 0; exe_m2reg = 0;
        mem_rn = '0; mem_wreg = 0; mem_m2reg = 0;
    endtask

    task automatic apply_reset();
        clrn = 1'b1;
        clear_inputs();
        step();
        clrn = 1'b0;
    endtask

    task automatic set_load_use_rt8();
        exe_m2reg = 1; exe_wreg = 1; exe_rn = 5'd8; id_rt = 5'd8; id_use_rt = 1;
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        clear_inputs();
        @(negedge clk);
        checks++; if (div_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", div_busy); end
        checks++; if (div_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", div_done); end
        checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (wpcir !== 1'b1 || id_bubble !== 1'b0) begin failures++; $display("FAIL reset_wpcir got=%b/%b exp=1/0", wpcir, id_bubble); end
        step();
        clrn = 1'b0;
    endtask

    task automatic test_forwarding();
        clear_inputs();
        @(negedge clk);
        exe_rn = 5; exe_wreg = 1; exe_m2reg = 0; mem_rn = 5; mem_wreg = 1;
        id_rs = 5; id_use_rs = 1; id_rt = 5; id_use_rt = 1;
        #1;
        checks++; if (fwda !== 2'b01) begin failures++; $display("FAIL fwd_exe got=%b exp=01", fwda); end
        checks++; if (fwdb !== 2'b01) begin failures++; $display("FAIL fwdb_exe got=%b exp=01", fwdb); end
        exe_wreg = 0; #1;
        checks++; if (fwda !== 2'b10) begin failures++; $display("FAIL fwd_mem_alu got=%b exp=10", fwda); end
        mem_m2reg = 1; #1;
        checks++; if (fwda !== 2'b11) begin failures++; $display("FAIL fwd_mem_mo got=%b exp=11", fwda); end
        id_rs = 0; #1;
        checks++; if (fwda !== 2'b00) begin failures++; $display("FAIL fwd_r0 got=%b exp=00", fwda); end
        id_use_rt = 0; #1;
        checks++; if (fwdb !== 2'b00) begin failures++; $display("FAIL fwd_nouse got=%b exp=00", fwdb); end
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use_rt8();
        @(negedge clk);
        checks++; if (wpcir !== 1'b0 || id_bubble !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b/%b exp=0/1", wpcir, id_bubble); end
        step();
        exe_m2reg = 0; exe_wreg = 0; exe_rn = 0;
        mem_rn = 8; mem_wreg = 1; mem_m2reg = 1;
        @(negedge clk);
        checks++; if (fwdb !== 2'b11) begin failures++; $display("FAIL lu_fwdb got=%b exp=11", fwdb); end
        checks++; if (wpcir !== 1'b1) begin failures++; $display("FAIL lu_release got=%b exp=1", wpcir); end
        checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        clear_inputs();
        step();
    endtask

    task automatic test_divide();
        apply_reset();
        id_is_div = 1;
        @(negedge clk);
        checks++; if (div_start !== 1'b1 || div_busy !== 1'b0) begin failures++; $display("FAIL div_launch got=%b/%b exp=1/0", div_start, div_busy); end
        step();
        id_is_div = 0; id_use_hilo = 1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (div_busy !== 1'b1 || wpcir !== 1'b0 || div_done !== 1'b0) begin
                failures++; $display("FAIL div_run c%0d got busy=%b wpcir=%b done=%b exp 1/0/0", c, div_busy, wpcir, div_done);
            end
            step();
        end
        @(negedge clk);
        checks++; if (div_done !== 1'b1 || div_busy !== 1'b0) begin failures++; $display("FAIL div_done got=%b/%b exp=1/0", div_done, div_busy); end
        checks++; if (wpcir !== 1'b1) begin failures++; $display("FAIL div_release got=%b exp=1", wpcir); end
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL div_cnt got=%0d exp=3", stall_cnt); end
        step();
        @(negedge clk);
        checks++; if (div_done !== 1'b0) begin failures++; $display("FAIL div_done_pulse got=%b exp=0", div_done); end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        id_is_div = 1;
        step();
        id_is_div = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) set_load_use_rt8(); else clear_inputs();
            @(negedge clk);
            checks++; if (div_busy !== 1'b1) begin failures++; $display("FAIL b2b_run c%0d got=%b exp=1", c, div_busy); end
            step();
        end
        clear_inputs();
        id_is_div = 1;
        @(negedge clk);
        checks++; if (div_done !== 1'b1 || div_start !== 1'b1) begin failures++; $display("FAIL b2b_relaunch got=%b/%b exp=1/1", div_done, div_start); end
        step();
        id_is_div = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++; if (div_busy !== 1'b1 || div_done !== 1'b0) begin failures++; $display("FAIL b2b_run2 c%0d got=%b/%b exp=1/0", c, div_busy, div_done); end
            step();
        end
        @(negedge clk);
        checks++; if (div_done !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", div_done); end
        checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL b2b_cnt got=%0d exp=1", stall_cnt); end
        step();
    endtask

    task automatic test_branch();
        apply_reset();
        id_branch_taken = 1;
        @(negedge clk);
        checks++; if (ifid_flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%b exp=1", ifid_flush); end
        step();
        set_load_use_rt8();
        @(negedge clk);
        checks++; if (ifid_flush !== 1'b0) begin failures++; $display("FAIL br_stalled got=%b exp=0", ifid_flush); end
        step();
        exe_m2reg = 0; exe_wreg = 0; exe_rn = 0;
        mem_rn = 8; mem_wreg = 1; mem_m2reg = 1;
        @(negedge clk);
        checks++; if (ifid_flush !== 1'b1) begin failures++; $display("FAIL br_retry got=%b exp=1", ifid_flush); end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_div();
        apply_reset();
        id_is_div = 1;
        step();
        id_is_div = 0; id_use_hilo = 1;
        step();
        @(negedge clk);
        checks++; if (div_busy !== 1'b1 || stall_cnt !== 4'd1) begin failures++; $display("FAIL rmd_pre got=%b/%0d exp=1/1", div_busy, stall_cnt); end
        clrn = 1'b1;
        #1;
        checks++; if (div_busy !== 1'b0) begin failures++; $display("FAIL rmd_busy got=%b exp=0", div_busy); end
        checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL rmd_cnt got=%0d exp=0", stall_cnt); end
        step();
        clrn = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (wpcir !== 1'b1 || div_done !== 1'b0) begin
                failures++; $display("FAIL rmd_after c%0d got wpcir=%b done=%b exp 1/0", c, wpcir, div_done);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int exp_c;
        apply_reset();
        set_load_use_rt8();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            exp_c = (c > SC_MAX) ? SC_MAX : c;
            checks++; if (stall_cnt !== CNT_W'(exp_c)) begin failures++; $display("FAIL sat c%0d got=%0d exp=%0d", c, stall_cnt, exp_c); end
            step();
        end
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", stall_cnt); end
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        logic [13:0] got, exp;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            exe_rn = 5'($urandom_range(0, 3));
            mem_rn = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            exe_wreg = 1'($urandom); exe_m2reg = 1'($urandom);
            mem_wreg = 1'($urandom); mem_m2reg = 1'($urandom);
            id_is_div = ($urandom_range(0, 5) == 0);
            id_use_hilo = ($urandom_range(0, 3) == 0);
            id_branch_taken = ($urandom_range(0, 3) == 0);
            clrn = ($urandom_range(0, 79) == 0);
            if (clrn) begin m_left = -1; m_sc = 0; end
            @(negedge clk);
            model_eval();
            got = {fwda, fwdb, wpcir, id_bubble, ifid_flush, div_start, div_busy, div_done, stall_cnt};
            exp = {e_fwda, e_fwdb, e_wpcir, e_bub, e_flush, e_start, e_busy, e_done, e_sc};
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL random n%0d got=%b exp=%b", n, got, exp);
            end
            step();
        end
        clrn = 1'b0;
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_left = -1;
        m_sc = 0;
        clrn = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_divide();
        test_back_to_back();
        test_branch();
        test_reset_mid_div();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
